rc4_encrypt_fsm: RTL and testbench

- RC4 PRGA encryptor, the transmit-side counterpart of the decrypt FSM.
- Reads a MSG_LEN-byte plaintext RAM, generates the keystream from an S-box RAM that has already been KSA-initialised, and writes plaintext XOR keystream to a ciphertext RAM.
- Its output image is what the decryptor's ROM holds.
- Rejects plaintext bytes outside the lowercase/space alphabet, so every ciphertext it emits passes the decryptor's character check.

---
 rtl/rc4_pkg.sv | 29 ++
 rtl/rc4_wait_counter.sv | 27 ++
 rtl/rc4_encrypt_fsm.sv | 135 +++++++++++++
 tb/tb_rc4_encrypt_fsm.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared state encoding, alphabet constants and character check for the RC4 FSMs
package rc4_pkg;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_FETCH_I,
        ST_WAIT_SI,
        ST_CALC_J,
        ST_ISSUE_SJ,
        ST_WAIT_SJ,
        ST_WR_SJ,
        ST_WR_SI,
        ST_READ_F,
        ST_WAIT_F,
        ST_XOR_WR,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    function automatic logic is_valid_char(input logic [7:0] c);
        return (c >= CHAR_LO && c <= CHAR_HI) || c == CHAR_SP;
    endfunction

endpackage

// File: rtl/rc4_wait_counter.sv
// rc4_wait_counter: RD_WAIT-cycle read-latency timer, loaded on entry to a wait state
module rc4_wait_counter #(
    parameter int RD_WAIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    localparam int W = RD_WAIT > 1 ? $clog2(RD_WAIT) : 1;

    logic [W-1:0] cnt;

    // reload with RD_WAIT-1 so the wait state lasts RD_WAIT cycles, then hold at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= W'(RD_WAIT - 1);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = cnt == '0;

endmodule

// File: rtl/rc4_encrypt_fsm.sv
// rc4_encrypt_fsm: RC4 PRGA encryptor, plaintext RAM XOR keystream into ciphertext RAM
module rc4_encrypt_fsm
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5,
    parameter int RD_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        s_q,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        pt_q,
    output logic [MSG_AW-1:0] pt_address,
    output logic [MSG_AW-1:0] ct_address,
    output logic [7:0]        ct_data,
    output logic              ct_wren,
    output logic              busy,
    output logic              done,
    output logic              bad_char
);

    state_t          state, state_n;
    logic [7:0]      i, j, si, sj;
    logic [MSG_AW:0] k;
    logic            expire, valid, last;

    assign valid = is_valid_char(pt_q);
    assign last  = k == (MSG_AW + 1)'(MSG_LEN - 1);

    rc4_wait_counter #(.RD_WAIT(RD_WAIT)) u_wait (
        .clk    (clk),
        .reset  (reset),
        .load   (state == ST_FETCH_I || state == ST_ISSUE_SJ || state == ST_READ_F),
        .expire (expire)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // next-state logic: one PRGA step per byte, waits gated by the read-latency timer
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:     if (start) state_n = ST_FETCH_I;
            ST_FETCH_I:  state_n = ST_WAIT_SI;
            ST_WAIT_SI:  if (expire) state_n = ST_CALC_J;
            ST_CALC_J:   state_n = ST_ISSUE_SJ;
            ST_ISSUE_SJ: state_n = ST_WAIT_SJ;
            ST_WAIT_SJ:  if (expire) state_n = ST_WR_SJ;
            ST_WR_SJ:    state_n = ST_WR_SI;
            ST_WR_SI:    state_n = ST_READ_F;
            ST_READ_F:   state_n = ST_WAIT_F;
            ST_WAIT_F:   if (expire) state_n = ST_XOR_WR;
            ST_XOR_WR:   state_n = valid ? ST_NEXT : ST_ERROR;
            ST_NEXT:     state_n = last ? ST_DONE : ST_FETCH_I;
            ST_DONE,
            ST_ERROR:    if (!start) state_n = ST_IDLE;
            default:     state_n = ST_IDLE;
        endcase
    end

    // PRGA index and swap registers; i/j/k cleared only when a run is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i  <= '0;
            j  <= '0;
            k  <= '0;
            si <= '0;
            sj <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    i <= '0;
                    j <= '0;
                    k <= '0;
                end
                ST_FETCH_I: i <= i + 8'd1;
                ST_CALC_J: begin
                    si <= s_q;
                    j  <= j + s_q;
                end
                ST_WR_SJ: sj <= s_q;
                ST_NEXT:  k <= k + 1'b1;
                default: ;
            endcase
        end
    end

    // RAM ports held steady through each wait so the read data is stable when sampled
    always_comb begin
        s_address = '0;
        s_data    = '0;
        s_wren    = 1'b0;
        ct_data   = '0;
        ct_wren   = 1'b0;
        case (state)
            ST_FETCH_I:               s_address = i + 8'd1;
            ST_WAIT_SI, ST_CALC_J:    s_address = i;
            ST_ISSUE_SJ, ST_WAIT_SJ:  s_address = j;
            ST_WR_SJ: begin
                s_address = j;
                s_data    = si;
                s_wren    = 1'b1;
            end
            ST_WR_SI: begin
                s_address = i;
                s_data    = sj;
                s_wren    = 1'b1;
            end
            ST_READ_F, ST_WAIT_F:     s_address = si + sj;
            ST_XOR_WR: begin
                s_address = si + sj;
                ct_wren   = valid;
                ct_data   = valid ? pt_q ^ s_q : '0;
            end
            default: ;
        endcase
    end

    assign busy       = !(state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    assign done       = state == ST_DONE;
    assign bad_char   = state == ST_ERROR;
    assign pt_address = busy ? k[MSG_AW-1:0] : '0;
    assign ct_address = busy ? k[MSG_AW-1:0] : '0;

endmodule

// File: tb/tb_rc4_encrypt_fsm.sv
// tb_rc4_encrypt_fsm: directed checks of the RC4 encryptor against a software PRGA model
module tb_rc4_encrypt_fsm;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, b_start = 1'b0, load = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] s_q, s_address, s_data, pt_q, ct_data;
    logic [4:0] pt_address, ct_address;
    logic       s_wren, ct_wren, busy, done, bad_char;

    logic [7:0] b_s_q, b_s_address, b_s_data, b_pt_q, b_ct_data;
    logic [8:0] b_pt_address, b_ct_address;
    logic       b_s_wren, b_ct_wren, b_busy, b_done, b_bad_char;

    rc4_encrypt_fsm #(.MSG_LEN(32), .MSG_AW(5), .RD_WAIT(2)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_q(s_q), .s_address(s_address), .s_data(s_data), .s_wren(s_wren),
        .pt_q(pt_q), .pt_address(pt_address), .ct_address(ct_address),
        .ct_data(ct_data), .ct_wren(ct_wren),
        .busy(busy), .done(done), .bad_char(bad_char)
    );

    rc4_encrypt_fsm #(.MSG_LEN(512), .MSG_AW(9), .RD_WAIT(2)) dut_big (
        .clk(clk), .reset(reset), .start(b_start),
        .s_q(b_s_q), .s_address(b_s_address), .s_data(b_s_data), .s_wren(b_s_wren),
        .pt_q(b_pt_q), .pt_address(b_pt_address), .ct_address(b_ct_address),
        .ct_data(b_ct_data), .ct_wren(b_ct_wren),
        .busy(b_busy), .done(b_done), .bad_char(b_bad_char)
    );

    logic [7:0] s_init [256];
    logic [7:0] s_mem [256];
    logic [7:0] b_s_mem [256];
    logic [7:0] pt_mem [32];
    logic [7:0] ct_mem [32];
    logic [7:0] b_ct_mem [512];
    logic [7:0] ks [512];

    // synchronous RAMs with one-cycle registered read; load copies s_init in and marks ct with 0xEE
    always @(posedge clk) begin
        if (load) begin
            for (int x = 0; x < 256; x++) begin
                s_mem[x]   <= s_init[x];
                b_s_mem[x] <= s_init[x];
            end
            for (int x = 0; x < 32; x++) ct_mem[x] <= 8'hEE;
        end else begin
            if (s_wren) s_mem[s_address] <= s_data;
            if (ct_wren) ct_mem[ct_address] <= ct_data;
            if (b_s_wren) b_s_mem[b_s_address] <= b_s_data;
            if (b_ct_wren) b_ct_mem[b_ct_address] <= b_ct_data;
        end
        s_q    <= s_mem[s_address];
        pt_q   <= pt_mem[pt_address];
        b_s_q  <= b_s_mem[b_s_address];
        b_pt_q <= 8'h20;
    end

    int cyc = 0, pulses = 0, overlap = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // count ciphertext pulses and any cycle where both write enables are high
    always @(negedge clk) begin
        if (ct_wren) pulses <= pulses + 1;
        if ((s_wren && ct_wren) || (b_s_wren && b_ct_wren)) overlap <= overlap + 1;
    end

    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load_mem();
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic ident();
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    endtask

    task automatic ksa(input logic [23:0] key);
        logic [7:0] jj, t;
        ident();
        jj = 8'h00;
        for (int x = 0; x < 256; x++) begin
            jj = jj + s_init[x] + key[8 * (2 - (x % 3)) +: 8];
            t = s_init[x];
            s_init[x] = s_init[jj];
            s_init[jj] = t;
        end
    endtask

    task automatic model(input int n);
        logic [7:0] s [256];
        logic [7:0] ii, jj, t, f;
        for (int x = 0; x < 256; x++) s[x] = s_init[x];
        ii = 8'h00;
        jj = 8'h00;
        for (int m = 0; m < n; m++) begin
            ii = ii + 8'd1;
            jj = jj + s[ii];
            t = s[ii];
            s[ii] = s[jj];
            s[jj] = t;
            f = s[ii] + s[jj];
            ks[m] = s[f];
        end
    endtask

    function automatic int ct_mism(input int n);
        int m = 0;
        for (int x = 0; x < n; x++) if ((ct_mem[x] ^ ks[x]) !== pt_mem[x]) m++;
        return m;
    endfunction

    task automatic wait_end(input int c0, output int cycles);
        cycles = -1;
        for (int n = 0; n < 2000 && cycles < 0; n++) begin
            step();
            if (done || bad_char) cycles = cyc - c0;
        end
    endtask

    task automatic run(output int cycles);
        int c0;
        start = 1'b1;
        c0 = cyc;
        wait_end(c0, cycles);
    endtask

    int cycles, p0, c0, mism;
    string msg;

    initial begin
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bad", bad_char, 0);
        check("rst_wren", {s_wren, ct_wren}, 0);
        check("rst_addr", {s_address, s_data, pt_address, ct_address, ct_data}, 0);
        reset = 1'b0;
        step();

        // identity S, "ab" followed by spaces
        ident();
        for (int x = 0; x < 32; x++) pt_mem[x] = 8'h20;
        pt_mem[0] = 8'h61;
        pt_mem[1] = 8'h62;
        load_mem();
        model(32);
        p0 = pulses;
        run(cycles);
        check("id_latency", cycles, 449);
        check("id_pulses", pulses - p0, 32);
        check("id_ct0", ct_mem[0], 8'h63);
        check("id_ct1", ct_mem[1], 8'h67);
        check("id_ct_all", ct_mism(32), 0);
        check("id_busy_done", busy, 0);
        repeat (20) step();
        check("hold_done", done, 1);
        check("hold_no_rerun", pulses - p0, 32);
        start = 1'b0;
        step();
        check("idle_after_done", {busy, done, bad_char}, 0);

        // key 000249 round trip over a lowercase sentence
        ksa(24'h000249);
        msg = "thequickbrownfoxjumpsoverthelazy";
        for (int x = 0; x < 32; x++) pt_mem[x] = msg[x];
        load_mem();
        model(32);
        run(cycles);
        check("ksa_latency", cycles, 449);
        check("ksa_roundtrip", ct_mism(32), 0);
        start = 1'b0;
        step();

        // uppercase at index 3 stops the run in ERROR
        ident();
        for (int x = 0; x < 32; x++) pt_mem[x] = 8'h61 + 8'(x % 26);
        pt_mem[3] = 8'h41;
        load_mem();
        model(32);
        p0 = pulses;
        run(cycles);
        check("bad_flag", bad_char, 1);
        check("bad_done", done, 0);
        check("bad_pulses", pulses - p0, 3);
        check("bad_ct_prefix", ct_mism(3), 0);
        check("bad_ct3_untouched", ct_mem[3], 8'hEE);
        repeat (5) step();
        check("bad_hold", {bad_char, done, busy}, 3'b100);
        start = 1'b0;
        step();
        check("bad_to_idle", {bad_char, busy}, 0);

        // async reset during the S[j] write of byte 5, then clean restart
        for (int x = 0; x < 32; x++) pt_mem[x] = 8'h61 + 8'(x % 26);
        load_mem();
        p0 = pulses;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 2000 && !(pulses - p0 == 5 && s_wren); n++) step();
        check("reach_wr_sj5", {pulses - p0 == 5, s_wren}, 2'b11);
        reset = 1'b1;
        #1;
        check("ar_wren", {s_wren, ct_wren}, 0);
        check("ar_status", {busy, done, bad_char}, 0);
        check("ar_addr", {s_address, s_data, pt_address}, 0);
        step();
        reset = 1'b0;
        step();
        load_mem();
        model(32);
        p0 = pulses;
        run(cycles);
        check("restart_latency", cycles, 449);
        check("restart_ct", ct_mism(32), 0);
        start = 1'b0;
        step();

        // start pulsed mid-run is ignored
        load_mem();
        p0 = pulses;
        start = 1'b1;
        c0 = cyc;
        step();
        start = 1'b0;
        for (int n = 0; n < 2000 && pulses - p0 < 10; n++) step();
        start = 1'b1;
        repeat (2) step();
        start = 1'b0;
        wait_end(c0, cycles);
        check("busy_start_latency", cycles, 449);
        check("busy_start_pulses", pulses - p0, 32);
        check("busy_start_ct", ct_mism(32), 0);
        step();
        check("busy_start_idle", {busy, done}, 0);

        // 512-byte build: i wraps past 255, keystream must stay in step with the model
        ident();
        load_mem();
        model(512);
        b_start = 1'b1;
        c0 = cyc;
        cycles = -1;
        for (int n = 0; n < 9000 && cycles < 0; n++) begin
            step();
            if (b_done || b_bad_char) cycles = cyc - c0;
        end
        b_start = 1'b0;
        check("big_latency", cycles, 512 * 14 + 1);
        mism = 0;
        for (int x = 0; x < 512; x++) if (b_ct_mem[x] !== (8'h20 ^ ks[x])) mism++;
        check("big_ct_wrap", mism, 0);
        check("wren_exclusive", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
